// File: rtl/as6501_run_ctrl_if.sv
// as6501_run_ctrl_if: control/status bundle between the AXI register block and the AS6501 run controller
interface as6501_run_ctrl_if;
  logic        cfg_start_i;
  logic        cfg_stop_i;
  logic        cfg_clear_i;
  logic [15:0] cfg_run_pps_i;
  logic        pps_i;
  logic        tdc_ovf_i;
  logic        fifo_empty_i;
  logic        tdc_rst_o;
  logic        fifo_calib_rst_o;
  logic        enable_o;
  logic        start_gc_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [2:0]  state_o;
  logic [15:0] pps_count_o;
  modport master (
    output cfg_start_i, cfg_stop_i, cfg_clear_i, cfg_run_pps_i, pps_i, tdc_ovf_i, fifo_empty_i,
    input  tdc_rst_o, fifo_calib_rst_o, enable_o, start_gc_o, busy_o, done_o, err_o,
           err_code_o, state_o, pps_count_o
  );
  modport slave (
    input  cfg_start_i, cfg_stop_i, cfg_clear_i, cfg_run_pps_i, pps_i, tdc_ovf_i, fifo_empty_i,
    output tdc_rst_o, fifo_calib_rst_o, enable_o, start_gc_o, busy_o, done_o, err_o,
           err_code_o, state_o, pps_count_o
  );
endinterface

// File: rtl/as6501_run_ctrl.sv
// as6501_run_ctrl: sequences one AS6501 acquisition run (reset, settle, PPS align, run, drain).
// AS6501_CTRL_PPS_ALIGN_EN enables the WAIT_PPS alignment state; undefined goes SETTLE -> RUN.
module as6501_run_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter int unsigned PPS_TIMEOUT   = 250_000_000,
  parameter int unsigned DRAIN_CYCLES  = 1024
) (
  input logic               lclk_i,
  input logic               arstn,
  as6501_run_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, RST, SETTLE, WAIT_PPS, RUN, DRAIN, DONE, ERROR} state_t;
`ifdef AS6501_CTRL_PPS_ALIGN_EN
  localparam state_t POST_SETTLE = WAIT_PPS;
`else
  localparam state_t POST_SETTLE = RUN;
`endif
  state_t      state, nstate;
  logic [31:0] tmr, ntmr;
  logic [15:0] cnt, ncnt, run_pps, nrun_pps, inc;
  logic [1:0]  code, ncode, sync;
  logic        dly, rise, tz, stop, ovf;
  assign tz   = tmr == '0;
  assign inc  = cnt == 16'hffff ? cnt : cnt + 16'd1;
  assign stop = bus.cfg_stop_i;
  assign ovf  = bus.tdc_ovf_i;
  assign bus.state_o     = state;
  assign bus.err_code_o  = code;
  assign bus.pps_count_o = cnt;
  always_comb begin
    nstate   = state;
    ncnt     = cnt;
    ncode    = code;
    nrun_pps = run_pps;
    case (state)
      IDLE:     if (bus.cfg_start_i) begin
                  nstate   = RST;
                  ncnt     = '0;
                  ncode    = '0;
                  nrun_pps = bus.cfg_run_pps_i;
                end
      RST:      nstate = stop ? DRAIN : tz ? SETTLE : RST;
      SETTLE:   nstate = stop ? DRAIN : tz ? POST_SETTLE : SETTLE;
      WAIT_PPS: if (ovf) begin
                  nstate = ERROR;
                  ncode  = 2'b10;
                end else if (stop) nstate = DRAIN;
                else if (rise) nstate = RUN;
                else if (tz) begin
                  nstate = ERROR;
                  ncode  = 2'b01;
                end
      RUN:      begin
                  if (rise) ncnt = inc;
                  if (ovf) begin
                    nstate = ERROR;
                    ncode  = 2'b10;
                  end else if (stop || (rise && run_pps != '0 && inc == run_pps)) nstate = DRAIN;
                end
      DRAIN:    if (bus.fifo_empty_i) nstate = DONE;
                else if (tz) begin
                  nstate = ERROR;
                  ncode  = 2'b11;
                end
      DONE:     nstate = IDLE;
      ERROR:    if (bus.cfg_clear_i) nstate = IDLE;
    endcase
  end
  // timer reloads on every state entry and counts down (holding at 0) while the state persists
  assign ntmr = nstate == state    ? (tz ? tmr : tmr - 32'd1)
              : nstate == RST      ? 32'(RST_CYCLES - 1)
              : nstate == SETTLE   ? 32'(SETTLE_CYCLES - 1)
              : nstate == WAIT_PPS ? 32'(PPS_TIMEOUT - 1)
              : nstate == DRAIN    ? 32'(DRAIN_CYCLES - 1) : '0;
  always_ff @(posedge lclk_i or negedge arstn) begin
    if (!arstn) begin
      state                <= IDLE;
      tmr                  <= '0;
      cnt                  <= '0;
      code                 <= '0;
      run_pps              <= '0;
      sync                 <= '0;
      dly                  <= 1'b0;
      rise                 <= 1'b0;
      bus.tdc_rst_o        <= 1'b0;
      bus.fifo_calib_rst_o <= 1'b0;
      bus.enable_o         <= 1'b0;
      bus.start_gc_o       <= 1'b0;
      bus.busy_o           <= 1'b0;
      bus.done_o           <= 1'b0;
      bus.err_o            <= 1'b0;
    end else begin
      state                <= nstate;
      tmr                  <= ntmr;
      cnt                  <= ncnt;
      code                 <= ncode;
      run_pps              <= nrun_pps;
      sync                 <= {sync[0], bus.pps_i};
      dly                  <= sync[1];
      rise                 <= sync[1] & ~dly;
      bus.tdc_rst_o        <= nstate == RST;
      bus.fifo_calib_rst_o <= nstate == RST;
      bus.enable_o         <= nstate inside {SETTLE, WAIT_PPS, RUN};
      bus.start_gc_o       <= nstate == RUN;
      bus.busy_o           <= !(nstate inside {IDLE, ERROR});
      bus.done_o           <= nstate == DONE;
      bus.err_o            <= nstate == ERROR;
    end
  end
endmodule

// File: tb/tb_as6501_run_ctrl.sv
// tb_as6501_run_ctrl: directed self-checking bench for as6501_run_ctrl
module tb_as6501_run_ctrl;
  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  int         checks = 0;
  int         failures = 0;
  logic [6:0] ctl;
  as6501_run_ctrl_if bus();
  as6501_run_ctrl #(
    .RST_CYCLES(4), .SETTLE_CYCLES(8), .PPS_TIMEOUT(100), .DRAIN_CYCLES(1024)
  ) dut (
    .lclk_i(clk),
    .arstn(arstn),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign ctl = {bus.tdc_rst_o, bus.fifo_calib_rst_o, bus.enable_o, bus.start_gc_o,
                bus.busy_o, bus.done_o, bus.err_o};
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go_run(input logic [15:0] n);
    bus.cfg_run_pps_i = n;
    bus.cfg_start_i = 1'b1;
    tick();
    bus.cfg_start_i = 1'b0;
    tick(12);
`ifdef AS6501_CTRL_PPS_ALIGN_EN
    bus.pps_i = 1'b1;
    tick(4);
    bus.pps_i = 1'b0;
    tick(4);
`endif
    chk("go_run_state", 32'(bus.state_o), 4);
  endtask
  task automatic pps_pulse();
    bus.pps_i = 1'b1;
    tick(4);
    bus.pps_i = 1'b0;
    tick(4);
  endtask
  initial begin
    bus.cfg_start_i = 1'b0;
    bus.cfg_stop_i = 1'b0;
    bus.cfg_clear_i = 1'b0;
    bus.cfg_run_pps_i = '0;
    bus.pps_i = 1'b0;
    bus.tdc_ovf_i = 1'b0;
    bus.fifo_empty_i = 1'b1;
    tick(2);
    chk("rst_ctl", 32'(ctl), 0);
    chk("rst_state", 32'(bus.state_o), 0);
    chk("rst_cnt", 32'(bus.pps_count_o), 0);
    chk("rst_code", 32'(bus.err_code_o), 0);
    arstn = 1'b1;
    tick();
    // nominal run of two PPS periods
    bus.cfg_run_pps_i = 16'd2;
    bus.cfg_start_i = 1'b1;
    tick();
    bus.cfg_start_i = 1'b0;
    bus.cfg_run_pps_i = 16'd7;
    for (int i = 0; i < 4; i++) begin
      chk("nom_tdc_rst_hi", 32'({bus.tdc_rst_o, bus.fifo_calib_rst_o, bus.enable_o}), 3'b110);
      tick();
    end
    chk("nom_settle", 32'({bus.tdc_rst_o, bus.enable_o, bus.state_o}), {2'b01, 3'd2});
    tick(7);
    chk("nom_settle_end", 32'(bus.state_o), 2);
    tick();
`ifdef AS6501_CTRL_PPS_ALIGN_EN
    chk("nom_wait_pps", 32'({bus.state_o, bus.start_gc_o}), {3'd3, 1'b0});
    bus.pps_i = 1'b1;
    tick(3);
    chk("nom_gc_pre", 32'(bus.start_gc_o), 0);
    tick();
    chk("nom_gc_rise", 32'({bus.state_o, bus.start_gc_o}), {3'd4, 1'b1});
    bus.pps_i = 1'b0;
    tick(4);
`else
    chk("nom_direct_run", 32'({bus.state_o, bus.start_gc_o, bus.enable_o}), {3'd4, 2'b11});
`endif
    chk("nom_cnt0", 32'(bus.pps_count_o), 0);
    pps_pulse();
    chk("nom_cnt1", 32'({bus.state_o, bus.pps_count_o}), {3'd4, 16'd1});
    bus.pps_i = 1'b1;
    tick(3);
    chk("nom_run_hold", 32'(bus.state_o), 4);
    tick();
    chk("nom_drain", 32'({bus.state_o, bus.start_gc_o, bus.enable_o, bus.pps_count_o}), {3'd5, 2'b00, 16'd2});
    bus.pps_i = 1'b0;
    tick();
    chk("nom_done", 32'({bus.state_o, bus.done_o}), {3'd6, 1'b1});
    tick();
    chk("nom_idle", 32'({bus.state_o, ctl}), {3'd0, 7'd0});
`ifdef AS6501_CTRL_PPS_ALIGN_EN
    // PPS never arrives
    bus.cfg_start_i = 1'b1;
    tick();
    bus.cfg_start_i = 1'b0;
    tick(12);
    tick(99);
    chk("to_wait_last", 32'(bus.state_o), 3);
    tick();
    chk("to_error", 32'({bus.state_o, bus.err_code_o, ctl}), {3'd7, 2'b01, 7'b0000001});
    bus.cfg_clear_i = 1'b1;
    tick();
    bus.cfg_clear_i = 1'b0;
    chk("to_clear", 32'(bus.state_o), 0);
`endif
    // overflow beats stop in the same cycle
    go_run(16'd0);
    bus.tdc_ovf_i = 1'b1;
    bus.cfg_stop_i = 1'b1;
    tick();
    bus.tdc_ovf_i = 1'b0;
    bus.cfg_stop_i = 1'b0;
    chk("ovf_error", 32'({bus.state_o, bus.err_code_o, ctl}), {3'd7, 2'b10, 7'b0000001});
    tick();
    chk("ovf_no_done", 32'({bus.state_o, bus.done_o}), {3'd7, 1'b0});
    bus.cfg_clear_i = 1'b1;
    bus.cfg_start_i = 1'b1;
    tick();
    bus.cfg_clear_i = 1'b0;
    bus.cfg_start_i = 1'b0;
    chk("ovf_clear_only", 32'({bus.state_o, bus.err_code_o}), {3'd0, 2'b10});
    tick();
    chk("ovf_start_ignored", 32'({bus.state_o, bus.tdc_rst_o}), {3'd0, 1'b0});
    // stop with a slow-draining FIFO
    bus.fifo_empty_i = 1'b0;
    go_run(16'd0);
    chk("stop_code_cleared", 32'(bus.err_code_o), 0);
    bus.cfg_stop_i = 1'b1;
    tick();
    bus.cfg_stop_i = 1'b0;
    chk("stop_drain", 32'({bus.state_o, bus.enable_o, bus.start_gc_o}), {3'd5, 2'b00});
    tick(49);
    chk("stop_drain_hold", 32'(bus.state_o), 5);
    bus.fifo_empty_i = 1'b1;
    tick();
    chk("stop_done", 32'({bus.state_o, bus.done_o}), {3'd6, 1'b1});
    tick();
    chk("stop_idle", 32'({bus.state_o, bus.done_o}), {3'd0, 1'b0});
    // drain timeout
    bus.fifo_empty_i = 1'b0;
    go_run(16'd0);
    bus.cfg_stop_i = 1'b1;
    tick();
    bus.cfg_stop_i = 1'b0;
    tick(1023);
    chk("dto_last_drain", 32'(bus.state_o), 5);
    tick();
    chk("dto_error", 32'({bus.state_o, bus.err_code_o, ctl}), {3'd7, 2'b11, 7'b0000001});
    bus.cfg_clear_i = 1'b1;
    tick();
    bus.cfg_clear_i = 1'b0;
    bus.fifo_empty_i = 1'b1;
    chk("dto_clear", 32'({bus.state_o, bus.err_code_o}), {3'd0, 2'b11});
    // asynchronous reset mid-run
    go_run(16'd0);
    pps_pulse();
    chk("ar_cnt1", 32'(bus.pps_count_o), 1);
    arstn = 1'b0;
    #1;
    chk("ar_async", 32'({bus.state_o, ctl, bus.pps_count_o}), 0);
    tick(2);
    arstn = 1'b1;
    tick();
    go_run(16'd0);
    chk("ar_fresh_cnt", 32'(bus.pps_count_o), 0);
    pps_pulse();
    chk("ar_fresh_cnt1", 32'(bus.pps_count_o), 1);
    bus.cfg_stop_i = 1'b1;
    tick();
    bus.cfg_stop_i = 1'b0;
    tick();
    chk("ar_done", 32'({bus.state_o, bus.done_o}), {3'd6, 1'b1});
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/as6501_run_ctrl.md
# as6501_run_ctrl

Run-sequencing controller for the AS6501 TDC capture path. It executes one acquisition run on command: TDC/calibration-FIFO reset, settle, PPS alignment, gated run and drain. It drives the interface's reset, enable and global-counter start. It sits between the AXI control registers and the AS6501 interface, in the lclk_i (200 MHz) domain.

## Interface
Parameters:
- RST_CYCLES, 16, cycles tdc_rst_o/fifo_calib_rst_o held high (≥1)
- SETTLE_CYCLES, 256, cycles after reset release before PPS wait (≥1)
- PPS_TIMEOUT, 250_000_000, max cycles in WAIT_PPS (1.25 s at 200 MHz)
- DRAIN_CYCLES, 1024, max cycles in DRAIN

Ports:
- lclk_i  in  1  clock; all logic on rising edge
- arstn  in  1  reset; asynchronous assert, active-low
- cfg_start_i  in  1  single-cycle start pulse
- cfg_stop_i  in  1  single-cycle abort pulse
- cfg_clear_i  in  1  clears ERROR
- cfg_run_pps_i  in  16  run length in PPS periods; 0 = unlimited
- pps_i  in  1  asynchronous PPS
- tdc_ovf_i  in  1  overflow from TDC interface/FIFO, level
- fifo_empty_i  in  1  downstream FIFO empty
- tdc_rst_o  out  1  TDC interface reset
- fifo_calib_rst_o  out  1  calibration FIFO reset
- enable_o  out  1  TDC interface enable
- start_gc_o  out  1  global-counter start, level
- busy_o  out  1  state not IDLE/ERROR
- done_o  out  1  one-cycle pulse on run completion
- err_o  out  1  state == ERROR
- err_code_o  out  2  01 PPS timeout, 10 overflow, 11 drain timeout, 00 none
- state_o  out  3  current state encoding
- pps_count_o  out  16  PPS edges counted in current/last run

## Operation
- States: IDLE=0, RST=1, SETTLE=2, WAIT_PPS=3, RUN=4, DRAIN=5, DONE=6, ERROR=7. One shared 32-bit down-counter `tmr`.
- IDLE: cfg_start_i -> RST, tmr=RST_CYCLES-1, pps_count cleared. err_code_o cleared on start.
- RST: tdc_rst_o=fifo_calib_rst_o=1. At tmr==0 -> SETTLE, tmr=SETTLE_CYCLES-1.
- SETTLE: enable_o=1. At tmr==0 -> WAIT_PPS, tmr=PPS_TIMEOUT-1.
- WAIT_PPS: enable_o=1. pps_rise -> RUN. At tmr==0 with no edge -> ERROR, code 01.
- RUN: enable_o=1, start_gc_o=1. Each pps_rise increments pps_count (saturating at 0xFFFF). Next-count == cfg_run_pps_i (nonzero) -> DRAIN. The aligning edge is not counted.
- DRAIN: enable_o=0, start_gc_o=0, tmr=DRAIN_CYCLES-1 on entry. fifo_empty_i==1 -> DONE. At tmr==0 while not empty -> ERROR, code 11.
- DONE: done_o=1 for one cycle -> IDLE.
- ERROR: all control outputs 0. cfg_clear_i -> IDLE, err_code_o retained until next start.
- PPS path: 2-flop synchronizer plus delay register. pps_rise = sync & ~delayed.
- Priority in RST..RUN each cycle: tdc_ovf_i (-> ERROR, code 10; RUN/WAIT_PPS only) > cfg_stop_i (-> DRAIN) > normal transition. In DRAIN, stop and ovf are ignored.
- cfg_start_i outside IDLE is ignored. cfg_start_i and cfg_clear_i together in ERROR: clear only.
- cfg_run_pps_i is sampled into a register on start. Changes mid-run have no effect.

## Timing
- Reset (arstn=0): state IDLE, every output 0, counters 0, synchronizer 0. Reset mid-run drops all outputs immediately (asynchronously).
- All outputs are registered and decoded from the registered state. Outputs change on the same edge the state changes.
- Start latency: tdc_rst_o rises 1 cycle after the cfg_start_i cycle and stays high exactly RST_CYCLES cycles.
- enable_o rises the cycle tdc_rst_o falls.
- pps_i sampled high at edge k -> start_gc_o high from edge k+3.
- Run end: the cycle after the terminating pps_rise, state DRAIN and start_gc_o=0.
- DRAIN with fifo_empty_i already high: DRAIN lasts 1 cycle, DONE 1 cycle, then IDLE.
- 32-bit tmr; parameters above 2^32-1 are illegal.

## Configuration
- AS6501_CTRL_PPS_ALIGN_EN defined: behaviour as above.
- Undefined: WAIT_PPS is never entered; SETTLE -> RUN directly. PPS timeout (code 01) cannot occur. The synchronizer and pps_count_o are still active, so run-length counting is unchanged.

## Test plan
- Nominal, RST_CYCLES=4, SETTLE_CYCLES=8, cfg_run_pps_i=2, PPS every 2000 cycles, fifo_empty_i=1 -> tdc_rst_o high exactly 4 cycles; start_gc_o rises 3 cycles after pps_i; pps_count_o=2; one done_o pulse; back to IDLE.
- PPS_TIMEOUT=100, pps_i held low -> ERROR after 100 WAIT_PPS cycles, err_code_o=01, outputs 0; cfg_clear_i -> IDLE.
- tdc_ovf_i pulse during RUN with cfg_stop_i in the same cycle -> ERROR, code 10; no done_o.
- cfg_stop_i in RUN, fifo_empty_i low 50 cycles then high, DRAIN_CYCLES=1024 -> enable_o low next cycle; DONE after empty; done_o pulse. Repeat with empty never high -> ERROR, code 11 after 1024 cycles.
- arstn asserted in RUN, released, then cfg_start_i -> outputs 0 during reset; fresh run with pps_count_o restarting at 0.
- Build without AS6501_CTRL_PPS_ALIGN_EN -> state goes 2->4 with no PPS; start_gc_o rises the cycle after SETTLE expires.
